// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the fetch stage: HLT opcode, bubble instruction and FSM states.
package fetch_stage_pkg;

   localparam logic [3:0]  OP_HLT  = 4'hF;
   localparam logic [15:0] NOP_ENC = 16'h0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HALT  = 2'd2
   } fetchState_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold freezes everything, otherwise it either captures a
// fetched instruction or loads a bubble.
module if_id_reg #(
   parameter int                 ADDR_W    = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               load,
   input  logic [INSTR_W-1:0] capInstr,
   input  logic [ADDR_W-1:0]  capPcPlus2,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pcPlus2,
   output logic               valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         instr   <= NOP_INSTR;
         pcPlus2 <= '0;
         valid   <= 1'b0;
      end else if (!hold) begin
         if (load) begin
            instr   <= capInstr;
            pcPlus2 <= capPcPlus2;
            valid   <= 1'b1;
         end else begin
            instr   <= NOP_INSTR;
            pcPlus2 <= '0;
            valid   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to imem with a valid handshake, handles
// stalls, branch redirects (including ones arriving during a miss) and HLT.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_FETCH | request at PC, imem_valid=1 captures and advances
//  ST_WAIT  | miss outstanding; address held until imem_valid
//  ST_HALT  | HLT captured; fetch frozen until rst
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                 ADDR_W    = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_req,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               imem_valid,
   output logic [INSTR_W-1:0] instr_FD,
   output logic [ADDR_W-1:0]  pc_plus2_FD,
   output logic               valid_FD,
   output logic               halted
);

   fetchState_t       state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pcPlus2;
   logic [ADDR_W-1:0] redirPc;
   logic              redirPend;
   logic              capture;
   logic              isHlt;

   assign pcPlus2   = pc + ADDR_W'(2);
   assign isHlt     = (imem_data[INSTR_W-1 -: 4] == OP_HLT);
   assign imem_addr = redirPend ? redirPc : pc;
   assign imem_req  = !rst && (state != ST_HALT);

   // A redirect pending in WAIT means the returning data belongs to the old path.
   always_comb begin
      capture = 1'b0;
      if (!br_taken && imem_valid) begin
         case (state)
            ST_FETCH: capture = 1'b1;
            ST_WAIT:  capture = !redirPend;
            default:  capture = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         pc        <= RESET_PC;
         redirPc   <= RESET_PC;
         redirPend <= 1'b0;
         halted    <= 1'b0;
      end else if (!stall) begin
         if (br_taken) begin
            if (state != ST_HALT) begin
               pc <= br_target;
            end
            if (state == ST_WAIT) begin
               redirPend <= 1'b1;
               redirPc   <= br_target;
            end
         end else begin
            case (state)
               ST_FETCH: begin
                  if (!imem_valid) begin
                     state <= ST_WAIT;
                  end else if (isHlt) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     pc <= pcPlus2;
                  end
               end
               ST_WAIT: begin
                  if (imem_valid) begin
                     if (redirPend) begin
                        pc        <= redirPc;
                        redirPend <= 1'b0;
                        state     <= ST_FETCH;
                     end else if (isHlt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end else begin
                        pc    <= pcPlus2;
                        state <= ST_FETCH;
                     end
                  end
               end
               ST_HALT: begin
                  halted <= 1'b1;
               end
               default: begin
                  state <= ST_FETCH;
               end
            endcase
         end
      end
   end

   // The ID stage must never resolve a branch once fetch has halted.
   assert property (@(posedge clk) disable iff (rst)
      !(state == ST_HALT && br_taken && !stall));

   if_id_reg #(
      .ADDR_W    (ADDR_W),
      .INSTR_W   (INSTR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_ifId (
      .clk        (clk),
      .rst        (rst),
      .hold       (stall),
      .load       (capture),
      .capInstr   (imem_data),
      .capPcPlus2 (pcPlus2),
      .instr      (instr_FD),
      .pcPlus2    (pc_plus2_FD),
      .valid      (valid_FD)
   );

endmodule
